alu64_arbiter_seq: RTL and testbench
====================================

Name: alu64_arbiter_seq

Overview:
- Shares one combinational `alu_64bit` instance between two requesters.
- Round-robin arbitration, operand latching and per-op latency sequencing.
- Slow ops are multiply, divide and modulo, with a configurable settle time.
- Results and flags return on one tagged valid/ready response channel.
- Sits between the issue logic of two compute lanes and the shared ALU.

Parameters:
- FAST_CYCLES, 1: EXEC cycles for sel not in {2,3,8}; legal 1..15.
- SLOW_CYCLES, 4: EXEC cycles for sel in {2,3,8} (mul/div/mod); legal 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  64  operand a
- req0_b  in  64  operand b
- req0_sel  in  6  opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1
- alu_a  out  64  to ALU a
- alu_b  out  64  to ALU b
- alu_sel  out  6  to ALU sel
- alu_result  in  64  ALU result
- alu_upper  in  64  ALU upper_result
- alu_flags  in  7  {sign,modulo,parity,negative,zero,overflow,carry}, bit0 = carry
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op
- rsp_result  out  64  captured result
- rsp_upper  out  64  captured upper_result
- rsp_flags  out  7  captured flags
- rsp_err  out  1  sel > 34 (unsupported opcode)
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - State IDLE; all data outputs 0.
  - rsp_valid=0, busy=0, req*_ready=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Cycle counter 0.
- State IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester != last_grant.
  - reqN_ready is combinational: (state==IDLE) && granted N. At most one ready is high per cycle.
  - On the grant edge:
    - latch a, b, sel into operand registers (which drive alu_a/b/sel);
    - latch rsp_id and last_grant;
    - load counter with (sel in {2,3,8} ? SLOW_CYCLES : FAST_CYCLES) - 1;
    - go to EXEC.
  - With no valid requester, stay in IDLE.
- State EXEC:
  - Operands are held stable.
  - Counter decrements each cycle.
  - In the cycle where counter==0:
    - capture alu_result, alu_upper, alu_flags into rsp_* registers;
    - set rsp_err = (sel > 34);
    - go to RESP with rsp_valid=1.
- State RESP:
  - rsp_valid=1 and all rsp_* fields are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge: rsp_valid=0, go to IDLE.
  - No bypass: the next grant occurs in IDLE at the earliest one cycle after the handshake.
- Latency:
  - Accept at edge T; rsp_valid rises at edge T+L, where L = FAST_CYCLES or SLOW_CYCLES.
  - Minimum issue interval is L+2 cycles.
- Operand hold:
  - alu_a/alu_b/alu_sel hold the last op in IDLE and RESP; no toggling between ops.
- Unsupported sel (35..63):
  - Sequenced with FAST_CYCLES.
  - The ALU value, 0 per its default arm, is captured as-is, with rsp_err=1.
- Requester rules:
  - reqN_valid may deassert without handshake; the block samples it only in IDLE.
  - A requester held off by contention is served next: there is no starvation with two requesters.
- Reset mid-operation:
  - Asynchronous return to reset values.
  - An in-flight op is dropped; no response is produced.
- rsp_flags are the ALU flags exactly as captured; the block performs no arithmetic.

Test Plan:
- Single op, defaults: req0 sel=0 a=64'hFFFF_FFFF_FFFF_FFFF b=1 -> req0_ready high at T, rsp_valid at T+1 edge, rsp_result=0, rsp_flags[0] (carry)=1, rsp_flags[2] (zero)=1, rsp_id=0.
- Slow op: req1 sel=3 a=100 b=7 -> rsp_valid exactly 4 cycles after accept, rsp_result=14, rsp_id=1; sel=2 a=2^63 b=4 -> rsp_upper=2, rsp_result=0.
- Contention: req0 and req1 both valid continuously with sel=9 -> grants strictly alternate 0,1,0,1, starting with 0; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 10 cycles during RESP -> rsp_* stable, both req*_ready stay 0; rsp_ready=1 -> next grant one cycle after the handshake.
- Unsupported opcode: sel=40 -> rsp_err=1, rsp_result=0, latency FAST_CYCLES.
- Reset mid-EXEC: rst_n low during a sel=8 op -> busy=0 and rsp_valid=0 immediately; no response after release; the next contention goes to req0.

Source files
------------

// File: rtl/alu64_arbiter_seq.sv
// Two-requester front end for a shared combinational 64-bit ALU.
// Round-robin grant, operand latching, per-opcode settle time and a
// tagged valid/ready response channel.
module alu64_arbiter_seq #(
    parameter int unsigned FAST_CYCLES = 1,
    parameter int unsigned SLOW_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [5:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [5:0]  req1_sel,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [5:0]  alu_sel,
    input  logic [63:0] alu_result,
    input  logic [63:0] alu_upper,
    input  logic [6:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic [63:0] rsp_upper,
    output logic [6:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] FAST_LOAD = 4'(FAST_CYCLES - 1);
    localparam logic [3:0] SLOW_LOAD = 4'(SLOW_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic [3:0]  cnt;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [5:0]  op_sel;

    logic        grant_any;
    logic        grant_id;
    logic [63:0] grant_a;
    logic [63:0] grant_b;
    logic [5:0]  grant_sel;
    logic        grant_slow;

    // Round-robin grant and operand selection; only meaningful in IDLE.
    always_comb begin
        grant_any = (state == IDLE) && (req0_valid || req1_valid);
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any && grant_id;
        grant_a    = grant_id ? req1_a   : req0_a;
        grant_b    = grant_id ? req1_b   : req0_b;
        grant_sel  = grant_id ? req1_sel : req0_sel;
        grant_slow = (grant_sel == 6'd2) || (grant_sel == 6'd3) || (grant_sel == 6'd8);
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch on grant, settle countdown, response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_upper  <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (grant_any) begin
                op_a       <= grant_a;
                op_b       <= grant_b;
                op_sel     <= grant_sel;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
                cnt        <= grant_slow ? SLOW_LOAD : FAST_LOAD;
            end else if (state == EXEC) begin
                if (cnt == 4'd0) begin
                    rsp_result <= alu_result;
                    rsp_upper  <= alu_upper;
                    rsp_flags  <= alu_flags;
                    rsp_err    <= (op_sel > 6'd34);
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_sel   = op_sel;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu64_arbiter_seq.sv
// Directed bench for alu64_arbiter_seq with a small stand-in ALU.
module tb_alu64_arbiter_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [5:0]  req0_sel = '0, req1_sel = '0;
    logic [63:0] alu_a, alu_b;
    logic [5:0]  alu_sel;
    logic [63:0] alu_result, alu_upper;
    logic [6:0]  alu_flags;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy;
    logic [63:0] rsp_result, rsp_upper;
    logic [6:0]  rsp_flags;

    int checks = 0;
    int errors = 0;

    alu64_arbiter_seq #(.FAST_CYCLES(1), .SLOW_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_upper(alu_upper), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_upper(rsp_upper), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: add, mul, div, mod, xor; everything else yields zero.
    always_comb begin
        logic [64:0]  sum;
        logic [127:0] prod;
        logic         known;
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        prod       = {64'd0, alu_a} * {64'd0, alu_b};
        alu_result = '0;
        alu_upper  = '0;
        alu_flags  = '0;
        known      = 1'b1;
        case (alu_sel)
            6'd0: alu_result = sum[63:0];
            6'd2: begin alu_result = prod[63:0]; alu_upper = prod[127:64]; end
            6'd3: alu_result = (alu_b != 0) ? alu_a / alu_b : 64'd0;
            6'd8: alu_result = (alu_b != 0) ? alu_a % alu_b : 64'd0;
            6'd9: alu_result = alu_a ^ alu_b;
            default: known = 1'b0;
        endcase
        if (known) begin
            alu_flags[0] = (alu_sel == 6'd0) ? sum[64] : 1'b0;
            alu_flags[2] = (alu_result == 64'd0);
            alu_flags[3] = alu_result[63];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [5:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [63:0] upper;
        logic [6:0]  flags;
        logic        err;
        int          lat;
    } vec_t;

    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        if (v.id == 1'b0) begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_sel = v.sel;
        end else begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_sel = v.sel;
        end
        #1;
        chk("accept_ready", v.id ? {63'd0, req1_ready} : {63'd0, req0_ready}, 64'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 40);
        chk("latency", 64'(lat), 64'(v.lat));
        chk("rsp_result", rsp_result, v.res);
        chk("rsp_upper", rsp_upper, v.upper);
        chk("rsp_flags", {57'd0, rsp_flags}, {57'd0, v.flags});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, v.err});
        chk("rsp_id", {63'd0, rsp_id}, {63'd0, v.id});
        repeat (2) @(posedge clk);
        #1;
        chk("rsp_held", {63'd0, rsp_valid}, 64'd1);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", {62'd0, rsp_valid, busy}, 64'd0);
        chk("hold_a", alu_a, v.a);
        chk("hold_sel", {58'd0, alu_sel}, {58'd0, v.sel});
    endtask

    vec_t vecs[11];

    initial begin
        logic held;
        int   grants, nrsp, last_cyc;

        vecs[0]  = '{1'b0, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 7'b0000101, 1'b0, 1};
        vecs[1]  = '{1'b1, 6'd3,  64'd100, 64'd7, 64'd14, 64'd0, 7'b0000000, 1'b0, 4};
        vecs[2]  = '{1'b0, 6'd2,  64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd2, 7'b0000100, 1'b0, 4};
        vecs[3]  = '{1'b1, 6'd40, 64'd5, 64'd6, 64'd0, 64'd0, 7'b0000000, 1'b1, 1};
        vecs[4]  = '{1'b0, 6'd8,  64'd100, 64'd7, 64'd2, 64'd0, 7'b0000000, 1'b0, 4};
        vecs[5]  = '{1'b1, 6'd9,  64'hF0, 64'hFF, 64'h0F, 64'd0, 7'b0000000, 1'b0, 1};
        vecs[6]  = '{1'b0, 6'd0,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 7'b0000101, 1'b0, 1};
        vecs[7]  = '{1'b1, 6'd34, 64'd3, 64'd4, 64'd0, 64'd0, 7'b0000000, 1'b0, 1};
        vecs[8]  = '{1'b0, 6'd35, 64'd3, 64'd4, 64'd0, 64'd0, 7'b0000000, 1'b1, 1};
        vecs[9]  = '{1'b1, 6'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'd0, 7'b0000000, 1'b0, 4};
        vecs[10] = '{1'b0, 6'd9,  64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 7'b0001000, 1'b0, 1};

        // Reset state
        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        chk("reset_alu_a", alu_a, 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i]);
        end

        // Backpressure: response held 10 cycles, then next grant right after handshake
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'hAAAA; req0_b = 64'h5555; req0_sel = 6'd9;
        #1;
        chk("bp_accept", {63'd0, req0_ready}, 64'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd0; req1_sel = 6'd9;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || rsp_result !== 64'hFFFF || rsp_id !== 1'b0 || req0_ready || req1_ready)
                held = 1'b0;
        end
        chk("bp_hold", {63'd0, held}, 64'd1);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp_handshake", {63'd0, rsp_valid}, 64'd0);
        chk("bp_next_grant", {62'd0, req0_ready, req1_ready}, 64'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during a slow op
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 64'd100; req1_b = 64'd7; req1_sel = 6'd8;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", {62'd0, busy, rsp_valid}, 64'd0);
        chk("mid_reset_alu_sel", {58'd0, alu_sel}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) held = 1'b0;
        end
        chk("no_rsp_after_reset", {63'd0, held}, 64'd1);

        // Contention: alternating grants starting with requester 0
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'h10; req0_b = 64'd0; req0_sel = 6'd9;
        req1_valid = 1'b1; req1_a = 64'h11; req1_b = 64'd0; req1_sel = 6'd9;
        rsp_ready = 1'b1;
        grants = 0;
        nrsp = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 200 && nrsp < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            chk("one_ready", {63'd0, req0_ready && req1_ready}, 64'd0);
            if (req0_ready || req1_ready) begin
                chk("grant_order", {63'd0, req1_ready}, 64'(grants % 2));
                if (last_cyc >= 0) chk("issue_interval", 64'(cyc - last_cyc), 64'd3);
                last_cyc = cyc;
                grants++;
            end
            if (rsp_valid) begin
                chk("contention_id", {63'd0, rsp_id}, 64'(nrsp % 2));
                chk("contention_result", rsp_result, (nrsp % 2) ? 64'h11 : 64'h10);
                nrsp++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("contention_done", 64'(nrsp), 64'd4);
        repeat (3) @(posedge clk);
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
